spi_frame_master: RTL and testbench

SPI_FRAME_MASTER -- requirements
Module: spi_frame_master

---
 rtl/spi_frame_master.sv | 96 +++++++++
 tb/tb_spi_frame_master.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// spi_frame_master: SPI mode-0 master that shifts one NBYTES frame from a TX buffer while filling an RX buffer
module spi_frame_master #(
  parameter int NBYTES = 20,
  parameter int CLKDIV = 4,
  parameter int LEAD = 4,
  parameter int GAP = 2,
  parameter int TRAIL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SSEL
);
  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_GAP, S_TRAIL, S_DONE} state_t;
  state_t st, nxt;
  logic [7:0] tx_mem [32];
  logic [7:0] rx_mem [32];
  logic [7:0] cnt, sh, rx_sh;
  logic [4:0] idx, ld_idx;
  logic [2:0] bc;
  logic h, m1, m2, half_end, fall, byte_end, more, load;
  assign busy = st != S_IDLE && st != S_DONE;
  assign done = st == S_DONE;
  assign SSEL = !busy;
  assign SCK = st == S_SHIFT && h;
  assign MOSI = st == S_SHIFT && sh[7];
  assign half_end = cnt == 8'(CLKDIV - 1);
  assign fall = st == S_SHIFT && half_end && h;
  assign byte_end = fall && bc == 3'd7;
  assign more = idx < 5'(NBYTES - 1);
  // with GAP=0 the next byte is loaded straight from SHIFT, before idx has advanced
  assign ld_idx = st == S_SHIFT ? idx + 5'd1 : idx;
  always_comb begin
    nxt = st;
    load = 1'b0;
    case (st)
      S_IDLE: nxt = start ? S_LEAD : S_IDLE;
      // LEAD holds for LEAD+1 cycles: the extra cycle is the frame's setup cycle
      S_LEAD: if (cnt == 8'(LEAD)) begin
        nxt = S_SHIFT;
        load = 1'b1;
      end
      S_SHIFT: if (byte_end) begin
        nxt = !more ? S_TRAIL : (GAP == 0 ? S_SHIFT : S_GAP);
        load = more && GAP == 0;
      end
      S_GAP: if (cnt == 8'(GAP - 1)) begin
        nxt = S_SHIFT;
        load = 1'b1;
      end
      S_TRAIL: nxt = cnt == 8'(TRAIL - 1) ? S_DONE : S_TRAIL;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      cnt <= '0;
      h <= 1'b0;
      bc <= '0;
      idx <= '0;
      sh <= '0;
      rx_sh <= '0;
      m1 <= 1'b0;
      m2 <= 1'b0;
      rd_data <= '0;
    end else begin
      st <= nxt;
      cnt <= (st == S_IDLE || nxt != st || load || (st == S_SHIFT && half_end)) ? 8'd0 : cnt + 8'd1;
      h <= (st == S_SHIFT && half_end) ? !h : h;
      bc <= fall ? bc + 3'd1 : bc;
      idx <= st == S_IDLE ? 5'd0 : (byte_end ? idx + 5'd1 : idx);
      sh <= load ? tx_mem[ld_idx] : (fall ? {sh[6:0], 1'b0} : sh);
      // sample the synchronized MISO during the first SCK-high cycle of each bit
      rx_sh <= (st == S_SHIFT && h && cnt == 8'd0) ? {rx_sh[6:0], m2} : rx_sh;
      m1 <= MISO;
      m2 <= m1;
      rd_data <= rd_addr < 5'(NBYTES) ? rx_mem[rd_addr] : 8'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && wr_en && !busy && wr_addr < 5'(NBYTES)) tx_mem[wr_addr] <= wr_data;
    if (!rst && byte_end) rx_mem[idx] <= rx_sh;
  end
endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: randomized scoreboard bench for spi_frame_master with loopback and fixed-MISO slaves
module tb_spi_frame_master;
  localparam int NB = 20, CD = 2, LD = 4, GP = 2, TR = 4;
  localparam int NB2 = 3, CD2 = 3, LD2 = 2, GP2 = 0, TR2 = 1;
  logic clk = 0, rst = 1, start = 0, start2 = 0, wr_en = 0, rd_req = 0, rd_chk = 0;
  logic lb = 1, miso_val = 1, chk_idle = 0, chk_rst = 1, fin = 0;
  logic [4:0] wr_addr = 0, rd_addr = 0;
  logic [7:0] wr_data = 0;
  logic busy, done, sck, mosi, ssel, miso;
  logic busy2, done2, sck2, mosi2, ssel2;
  logic [7:0] rd_data, rd_data2;
  int checks = 0, errors = 0;
  logic [7:0] tx_m [32];
  logic [7:0] rx_m [32];
  typedef struct {bit sel; logic [4:0] addr; logic [7:0] exp;} rd_t;
  rd_t rd_q[$];
  rd_t rdr;
  int busy_q[$], busy2_q[$];
  logic [7:0] mosi_q[$];
  assign miso = lb ? ~mosi : miso_val;
  always #5 clk = ~clk;
  spi_frame_master #(.NBYTES(NB), .CLKDIV(CD), .LEAD(LD), .GAP(GP), .TRAIL(TR)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .SCK(sck), .MOSI(mosi), .MISO(miso), .SSEL(ssel));
  spi_frame_master #(.NBYTES(NB2), .CLKDIV(CD2), .LEAD(LD2), .GAP(GP2), .TRAIL(TR2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data2), .SCK(sck2), .MOSI(mosi2), .MISO(~mosi2), .SSEL(ssel2));
  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction
  always @(posedge clk) rd_chk <= rd_req;
  int bcnt = 0, bcnt2 = 0, hi = 0, mbits = 0;
  logic sck_p = 0;
  logic [7:0] mbyte = 0;
  bit fin_seen = 0;
  always @(negedge clk) begin
    if (rd_chk) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        rdr = rd_q.pop_front();
        chk($sformatf("rd%0d_addr%0d", rdr.sel, rdr.addr), int'(rdr.sel ? rd_data2 : rd_data), int'(rdr.exp));
      end
    end
    if (chk_rst) begin
      chk("rst_ssel", int'(ssel), 1);
      chk("rst_sck", int'(sck), 0);
      chk("rst_mosi", int'(mosi), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rd_data", int'(rd_data), 0);
    end
    if (chk_idle) begin
      chk("idle_busy", int'(busy), 0);
      chk("idle_ssel", int'(ssel), 1);
    end
    if (ssel) begin
      chk("ssel_high_sck", int'(sck), 0);
      chk("ssel_high_mosi", int'(mosi), 0);
    end
    if (ssel2) chk("ssel2_high_sck", int'(sck2), 0);
    if (busy) bcnt++;
    if (busy2) bcnt2++;
    if (rst) begin
      bcnt = 0;
      bcnt2 = 0;
    end
    if (done) begin
      if (busy_q.size() == 0) chk("done_unexpected", 1, 0);
      else chk("busy_cycles", bcnt, busy_q.pop_front());
      bcnt = 0;
    end
    if (done2) begin
      if (busy2_q.size() == 0) chk("done2_unexpected", 1, 0);
      else chk("busy2_cycles", bcnt2, busy2_q.pop_front());
      bcnt2 = 0;
    end
    if (!ssel) begin
      if (sck) hi++;
      if (sck && !sck_p) begin
        mbyte = {mbyte[6:0], mosi};
        mbits++;
      end
      if (!sck && sck_p) begin
        chk("sck_high_cycles", hi, CD);
        hi = 0;
        if (mbits == 8) begin
          if (mosi_q.size() == 0) chk("mosi_unexpected", 1, 0);
          else chk("mosi_byte", int'(mbyte), int'(mosi_q.pop_front()));
          mbits = 0;
        end
      end
    end else begin
      hi = 0;
      mbits = 0;
    end
    sck_p = sck;
    if (fin && !fin_seen) begin
      fin_seen = 1;
      chk("busy_q_left", busy_q.size(), 0);
      chk("busy2_q_left", busy2_q.size(), 0);
      chk("mosi_q_left", mosi_q.size(), 0);
      chk("rd_q_left", rd_q.size(), 0);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [7:0] d, input bit accepted);
    @(posedge clk); #1;
    wr_en = 1; wr_addr = a; wr_data = d;
    if (accepted && a < NB) tx_m[a] = d;
    @(posedge clk); #1;
    wr_en = 0;
  endtask
  task automatic rd(input bit sel, input logic [4:0] a, input logic [7:0] e);
    @(posedge clk); #1;
    rd_addr = a; rd_req = 1;
    rd_q.push_back('{sel, a, e});
    @(posedge clk); #1;
    rd_req = 0;
  endtask
  task automatic pulse_start();
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
  endtask
  task automatic go(input bit lbk, input logic mv);
    lb = lbk; miso_val = mv;
    busy_q.push_back(1 + LD + NB * 16 * CD + (NB - 1) * GP + TR);
    for (int i = 0; i < NB; i++) begin
      mosi_q.push_back(tx_m[i]);
      rx_m[i] = lbk ? ~tx_m[i] : {8{mv}};
    end
    pulse_start();
  endtask
  task automatic wait_done(input bit second);
    int n = 0;
    while ((second ? done2 : done) !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        $display("FAIL frame_timeout: no done after %0d cycles", n);
        $fatal(1);
      end
    end
  endtask
  task automatic rand_tx();
    for (int i = 0; i < NB; i++) wr(5'(i), 8'($urandom), 1);
  endtask
  initial begin
    cyc(2);
    rst = 0; chk_rst = 0;
    for (int i = 0; i < NB; i++) wr(5'(i), 8'(i), 1);
    go(1, 1'b1);
    wait_done(0);
    start = 1;
    @(posedge clk); #1;
    start = 0; chk_idle = 1;
    cyc(3);
    chk_idle = 0;
    rd(0, 5'd19, rx_m[19]);
    rd(0, 5'd0, rx_m[0]);
    wr(5'd25, 8'h5A, 1);
    rd(0, 5'd25, 8'h00);
    rand_tx();
    wr(5'd0, 8'hA5, 1);
    go(0, 1'b1);
    cyc(9);
    pulse_start();
    cyc(38);
    pulse_start();
    wr(5'd3, ~tx_m[3], 0);
    wait_done(0);
    cyc(2);
    rd(0, 5'd0, 8'hFF);
    rd(0, 5'd3, 8'hFF);
    go(1, 1'b1);
    wait_done(0);
    cyc(2);
    for (int i = 0; i < 3; i++) begin
      automatic logic [4:0] a = 5'($urandom_range(0, NB - 1));
      rd(0, a, rx_m[a]);
    end
    rand_tx();
    lb = 1;
    for (int i = 0; i < 5; i++) begin
      mosi_q.push_back(tx_m[i]);
      rx_m[i] = ~tx_m[i];
    end
    pulse_start();
    cyc(190);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; chk_rst = 1;
    @(posedge clk); #1;
    chk_rst = 0;
    cyc(700);
    for (int i = 0; i < NB; i++) rd(0, 5'(i), rx_m[i]);
    busy2_q.push_back(1 + LD2 + NB2 * 16 * CD2 + (NB2 - 1) * GP2 + TR2);
    @(posedge clk); #1; start2 = 1;
    @(posedge clk); #1; start2 = 0;
    wait_done(1);
    cyc(2);
    for (int i = 0; i < NB2; i++) rd(1, 5'(i), ~tx_m[i]);
    rd(1, 5'd3, 8'h00);
    fin = 1;
    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
